// File: rtl/byte_divider.sv
// Restoring divider: one quotient bit per clock, start/busy/done handshake.
// Latency WIDTH_N cycles from accept to done (same-edge done for divide-by-zero).
module byte_divider #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH_N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH_N-1:0] q_sh, q_sh_nxt;
  logic [WIDTH_D:0]   p_rem, p_rem_nxt;
  logic [WIDTH_D-1:0] d_lat, d_lat_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH_N-1:0] quot_nxt;
  logic [WIDTH_D-1:0] rem_nxt;
  logic               dbz_nxt, done_nxt;

  // P's MSB is always zero after a restore step; including it in the
  // trial value keeps the compare exact without changing the result.
  logic [WIDTH_D+1:0] trial;
  logic               ge;

  assign trial = {p_rem, q_sh[WIDTH_N-1]};
  assign ge    = (trial >= {2'b00, d_lat});
  assign busy  = (state == S_DIVIDE);

  always_comb begin
    state_nxt = state;
    q_sh_nxt  = q_sh;
    p_rem_nxt = p_rem;
    d_lat_nxt = d_lat;
    cnt_nxt   = cnt;
    quot_nxt  = quotient;
    rem_nxt   = remainder;
    dbz_nxt   = div_by_zero;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_sh_nxt  = dividend;
            p_rem_nxt = '0;
            d_lat_nxt = divisor;
            cnt_nxt   = CW'(WIDTH_N);
            state_nxt = S_DIVIDE;
          end else begin
            quot_nxt  = '1;
            rem_nxt   = dividend[WIDTH_D-1:0];
            dbz_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DIVIDE: begin
        p_rem_nxt = ge ? (WIDTH_D+1)'(trial - {2'b00, d_lat}) : trial[WIDTH_D:0];
        q_sh_nxt  = {q_sh[WIDTH_N-2:0], ge};
        cnt_nxt   = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          quot_nxt  = q_sh_nxt;
          rem_nxt   = p_rem_nxt[WIDTH_D-1:0];
          dbz_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      q_sh        <= '0;
      p_rem       <= '0;
      d_lat       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      q_sh        <= q_sh_nxt;
      p_rem       <= p_rem_nxt;
      d_lat       <= d_lat_nxt;
      cnt         <= cnt_nxt;
      quotient    <= quot_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dbz_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_byte_divider.sv
// Scoreboard bench for byte_divider: directed operands, monitor checks each done pulse.
module tb_byte_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  byte_divider #(.WIDTH_N(16), .WIDTH_D(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {16'd0, quotient}, {16'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
      end
    end
  end

  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er,
                         input logic ez, input int exp_lat);
    int cyc;
    int bcnt;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back('{eq, er, ez});
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    cyc  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy === 1'b1 && done !== 1'b1) bcnt++;
    end
    chk("latency", cyc, exp_lat);
    chk("busy_cycles", bcnt, exp_lat);
    @(posedge clk);
    #1;
    chk("done_single", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", {16'd0, quotient}, 32'd0);
    chk("rst_rem", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_div(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16);
    run_div(16'h7530, 8'h96, 16'h00C8, 8'h00, 1'b0, 16);
    run_div(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16);
    run_div(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16);
    run_div(16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 16);
    run_div(16'h0000, 8'h80, 16'h0000, 8'h00, 1'b0, 16);
    run_div(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 0);
    run_div(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16);

    // start held high; operands change right after the first accept
    @(negedge clk);
    dividend = 16'h03E8;
    divisor  = 8'h07;
    start    = 1'b1;
    sb.push_back('{16'h008E, 8'h06, 1'b0});
    @(posedge clk);
    #1;
    dividend = 16'hFFFF;
    divisor  = 8'hFF;
    sb.push_back('{16'h0101, 8'h00, 1'b0});
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("hs_first_lat", cyc, 16);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) chk("hs_idle_not_busy", {31'd0, busy}, 32'd0);
      if (cyc == 2) chk("hs_second_accept", {31'd0, busy}, 32'd1);
      if (cyc == 4) chk("hs_quot_hold", {16'd0, quotient}, 32'h008E);
    end while (done !== 1'b1 && cyc < 60);
    start = 1'b0;
    chk("hs_second_gap", cyc, 18);
    @(posedge clk);
    #1;

    // asynchronous reset eight cycles into a division
    @(negedge clk);
    dividend = 16'h03E8;
    divisor  = 8'h07;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_quot", {16'd0, quotient}, 32'd0);
    chk("arst_rem", {24'd0, remainder}, 32'd0);
    chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_abort", {31'd0, done}, 32'd0);
    run_div(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/byte_divider.md
Name: byte_divider

Overview:
- Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient, 8-bit remainder.
- Inverse companion to the 8x8 array multiplier; takes a 16-bit product-width operand back down to byte operands.
- Processes one quotient bit per clock.
- Uses a start/busy/done handshake so a controller or lab top-level can sequence operations.

Parameters:
WIDTH_N, 16, dividend and quotient width
WIDTH_D, 8, divisor and remainder width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset)
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH_N  numerator; sampled on the accepting edge
divisor  input  WIDTH_D  denominator; sampled on the accepting edge
busy  output  1  high while state is DIVIDE
done  output  1  one-cycle pulse; results valid and stable
quotient  output  WIDTH_N  result, registered
remainder  output  WIDTH_D  result, registered
div_by_zero  output  1  registered; set at completion when the sampled divisor was 0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, div_by_zero = 0.
  - quotient and remainder = 0.
  - Internal shift, partial-remainder and counter registers = 0.
  - Any in-progress division is aborted and no done is generated.
- Internal registers:
  - Q shift register: WIDTH_N bits.
  - Partial remainder P: WIDTH_D+1 bits.
  - Latched divisor D: WIDTH_D bits.
  - Bit counter: $clog2(WIDTH_N)+1 bits.
- State machine: IDLE, DIVIDE, DONE.
- IDLE:
  - On an edge with start=1 and divisor!=0: Q<=dividend, P<=0, D<=divisor, counter<=WIDTH_N, go to DIVIDE.
  - On an edge with start=1 and divisor==0: go to DONE. In the same edge, quotient<={WIDTH_N{1}}, remainder<=dividend[WIDTH_D-1:0], div_by_zero<=1, done<=1.
- DIVIDE (one bit per edge):
  - Compute T = {P[WIDTH_D-1:0], Q[WIDTH_N-1]}.
  - If T >= {0,D}: P<=T-{0,D}, Q<={Q[WIDTH_N-2:0],1}.
  - Otherwise: P<=T, Q<={Q[WIDTH_N-2:0],0}.
  - Decrement counter.
  - On the edge where the counter goes 1->0: write the final Q to quotient and the final P[WIDTH_D-1:0] to remainder; div_by_zero<=0, done<=1, go to DONE.
- DONE: done<=0 and go to IDLE on the next edge. start is ignored in DONE.
- Latency:
  - Start accepted at edge N -> done high between edges N+WIDTH_N and N+WIDTH_N+1 (16 cycles by default).
  - Divide-by-zero case: done high between edges N and N+1.
  - Earliest next accept is edge N+WIDTH_N+2.
- busy:
  - High exactly while state=DIVIDE.
  - Low in IDLE and DONE, and during a divide-by-zero completion.
- start while busy or in DONE is ignored; no queueing.
- Operands are captured only on the accepting edge. Later changes to dividend/divisor have no effect on the operation in flight.
- Output holding:
  - quotient, remainder and div_by_zero hold their last result until the next completion overwrites them.
  - They are not cleared by a new start.
- Arithmetic invariant (divisor!=0): dividend == quotient*divisor + remainder, with remainder < divisor. Unsigned only.
- P needs WIDTH_D+1 bits so that T never overflows when D has its MSB set.
- Combinational logic is limited to the compare/subtract and next-state logic. All outputs are registered.

Test Plan:
- dividend=16'h03E8, divisor=8'h07, start pulsed 1 cycle -> busy high 16 cycles; done pulses once on the 16th edge after accept; quotient=16'h008E, remainder=8'h06, div_by_zero=0.
- Multiplier round-trip: dividend=16'h7530 (200*150), divisor=8'h96 -> quotient=16'h00C8, remainder=8'h00. Also dividend=16'hFFFF, divisor=8'hFF -> quotient=16'h0101, remainder=8'h00. Also dividend=16'hFFFF, divisor=8'h01 -> quotient=16'hFFFF, remainder=8'h00.
- Small and edge operands: dividend=16'h0005, divisor=8'h09 -> quotient=0, remainder=5. Then dividend=16'h0000, divisor=8'h80 -> quotient=0, remainder=0.
- Divide by zero: dividend=16'h1234, divisor=8'h00 -> done on the edge after accept; busy never high; quotient=16'hFFFF, remainder=8'h34, div_by_zero=1. A following valid division clears div_by_zero to 0.
- Handshake and input isolation: start held high continuously with operands changed mid-operation -> first operation's result is unaffected. A new operation is accepted only after DONE->IDLE, i.e. two edges after the done edge, and produces its own correct result.
- Reset mid-operation: assert reset=0 asynchronously 8 cycles into DIVIDE -> all outputs 0 immediately; no done. After reset release, start a new division (16'h03E8/8'h07) -> correct result 16'h008E / 8'h06.
